conv_alu: RTL and testbench

Single-clock convolution stage downstream of the frame-buffer memory controller. It accepts a KSIZE×KSIZE window of RGB444 pixels together with the window's centre address, and runs a sequential multiply-accumulate over programmable signed coefficients for the three colour lanes in parallel. It then normalises and clamps the result and issues a single-cycle write of the pixel back into the full frame buffer through the controller's processing write port.

---
 rtl/conv_alu_pkg.sv | 26 ++
 rtl/conv_alu_mac_lane.sv | 79 +++++++
 rtl/conv_alu.sv | 169 ++++++++++++++++
 tb/tb_conv_alu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_alu_pkg.sv
// Shared constants and FSM encoding for the conv_alu convolution stage.
// The absolute-value option in the lanes is selected by the CONV_ABS_EN macro.
package conv_alu_pkg;

    localparam int KSIZE_DEF  = 5;
    localparam int TAPS_DEF   = KSIZE_DEF * KSIZE_DEF;
    localparam int SHIFT_DEF  = 4;
    localparam int LANE_W     = 4;
    localparam int R_LSB      = 8;
    localparam int G_LSB      = 4;
    localparam int B_LSB      = 0;
    localparam int CENTRE_DEF = TAPS_DEF / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACC   = 2'b01,
        ST_NORM  = 2'b10,
        ST_WRITE = 2'b11
    } conv_state_e;

    // Row-major index of the kernel centre; holds the identity coefficient after reset.
    function automatic int centre_idx(input int ksize);
        return (ksize * ksize) / 2;
    endfunction

endpackage

// File: rtl/conv_alu_mac_lane.sv
// One colour lane: 4-bit pixel x signed coefficient MAC, then shift and clamp to 0..15.
// With CONV_ABS_EN defined, negative results are folded to their magnitude before clamping.
module conv_mac_lane
    import conv_alu_pkg::*;
#(
    parameter int COEFW = 8,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc_en,
    input  logic              norm_en,
    input  logic [LANE_W-1:0] pix,
    input  logic [COEFW-1:0]  coef,
    output logic [LANE_W-1:0] result
);

    localparam int PW   = COEFW + 5;
    localparam int ACCW = COEFW + 10;

    logic signed [PW-1:0]   pix_ext_s;
    logic signed [PW-1:0]   coef_ext_s;
    logic signed [PW-1:0]   prod_s;
    logic signed [ACCW-1:0] acc_r;
    logic signed [ACCW-1:0] shifted_s;
    logic signed [ACCW-1:0] mag_s;
    logic [LANE_W-1:0]      clamp_s;
    logic [LANE_W-1:0]      result_r;

    assign pix_ext_s  = {{(PW-LANE_W){1'b0}}, pix};
    assign coef_ext_s = {{(PW-COEFW){coef[COEFW-1]}}, coef};
    assign prod_s     = pix_ext_s * coef_ext_s;
    assign result     = result_r;

    // Accumulator: cleared when a window is accepted, one product added per ACC cycle.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            acc_r <= {ACCW{1'b0}};
        end else if (clr) begin
            acc_r <= {ACCW{1'b0}};
        end else if (acc_en) begin
            acc_r <= acc_r + {{(ACCW-PW){prod_s[PW-1]}}, prod_s};
        end
    end

    // Normalise, optional magnitude, clamp to the 4-bit range.
    always_comb begin
        shifted_s = acc_r >>> SHIFT;
        mag_s     = shifted_s;
        clamp_s   = {LANE_W{1'b0}};
`ifdef CONV_ABS_EN
        if (shifted_s[ACCW-1]) begin
            mag_s = -shifted_s;
        end else begin
            mag_s = shifted_s;
        end
`else
        mag_s = shifted_s;
`endif
        if (mag_s[ACCW-1]) begin
            clamp_s = {LANE_W{1'b0}};
        end else if (|mag_s[ACCW-2:LANE_W]) begin
            clamp_s = {LANE_W{1'b1}};
        end else begin
            clamp_s = mag_s[LANE_W-1:0];
        end
    end

    // Result register, loaded in NORM and held until the next window's NORM.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            result_r <= {LANE_W{1'b0}};
        end else if (norm_en) begin
            result_r <= clamp_s;
        end
    end

endmodule

// File: rtl/conv_alu.sv
// Convolution stage: snapshots a KSIZE x KSIZE RGB444 window, runs three parallel MAC lanes
// over a programmable coefficient file and writes one pixel back. Option macro: CONV_ABS_EN.
module conv_alu
    import conv_alu_pkg::*;
#(
    parameter int KSIZE  = KSIZE_DEF,
    parameter int DWIDTH = 12,
    parameter int AWIDTH = 19,
    parameter int COEFW  = 8,
    parameter int SHIFT  = SHIFT_DEF
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      win_valid,
    output logic                      win_ready,
    input  logic [KSIZE*KSIZE*DWIDTH-1:0] win_data,
    input  logic [AWIDTH-1:0]         win_addr,
    input  logic                      coef_wen,
    input  logic [4:0]                coef_idx,
    input  logic [COEFW-1:0]          coef_data,
    output logic [AWIDTH-1:0]         waddr_alu,
    output logic [DWIDTH-1:0]         wdata_alu,
    output logic                      wen_alu,
    output logic                      busy
);

    localparam int               TAPS       = KSIZE * KSIZE;
    localparam int               WINW       = TAPS * DWIDTH;
    localparam int               CENTRE     = centre_idx(KSIZE);
    localparam logic [4:0]       TAP_LAST   = 5'(TAPS - 1);
    localparam logic [COEFW-1:0] IDENT_COEF = COEFW'(1 << SHIFT);

    conv_state_e       state_r;
    conv_state_e       state_nx_s;
    logic [WINW-1:0]   win_r;
    logic [AWIDTH-1:0] addr_r;
    logic [AWIDTH-1:0] waddr_r;
    logic [4:0]        tap_r;
    logic [COEFW-1:0]  coef_r [TAPS];
    logic              wen_r;
    logic              accept_s;
    logic              acc_en_s;
    logic              norm_en_s;
    logic              coef_we_s;
    logic [DWIDTH-1:0] pix_s;
    logic [COEFW-1:0]  coef_sel_s;
    logic [LANE_W-1:0] res_r_s;
    logic [LANE_W-1:0] res_g_s;
    logic [LANE_W-1:0] res_b_s;

    assign accept_s   = (state_r == ST_IDLE) && win_valid;
    assign acc_en_s   = (state_r == ST_ACC);
    assign norm_en_s  = (state_r == ST_NORM);
    assign coef_we_s  = (state_r == ST_IDLE) && coef_wen && (coef_idx <= TAP_LAST);
    assign pix_s      = win_r[int'(tap_r)*DWIDTH +: DWIDTH];
    assign coef_sel_s = coef_r[tap_r];

    assign win_ready  = (state_r == ST_IDLE);
    assign busy       = (state_r != ST_IDLE);
    assign waddr_alu  = waddr_r;
    assign wen_alu    = wen_r;
    assign wdata_alu  = {res_r_s, res_g_s, res_b_s};

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: IDLE -> ACC for TAPS cycles -> NORM -> WRITE -> IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid) begin
                    state_nx_s = ST_ACC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (tap_r == TAP_LAST) begin
                    state_nx_s = ST_NORM;
                end else begin
                    state_nx_s = ST_ACC;
                end
            end
            ST_NORM:  state_nx_s = ST_WRITE;
            ST_WRITE: state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Window snapshot and tap counter; the counter saturates so it never indexes past the window.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            win_r  <= {WINW{1'b0}};
            addr_r <= {AWIDTH{1'b0}};
            tap_r  <= 5'd0;
        end else if (accept_s) begin
            win_r  <= win_data;
            addr_r <= win_addr;
            tap_r  <= 5'd0;
        end else if (acc_en_s && (tap_r != TAP_LAST)) begin
            tap_r  <= tap_r + 5'd1;
        end
    end

    // Write-port outputs: strobe is high for exactly the WRITE cycle, address then held.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wen_r   <= 1'b0;
            waddr_r <= {AWIDTH{1'b0}};
        end else begin
            wen_r <= norm_en_s;
            if (norm_en_s) begin
                waddr_r <= addr_r;
            end
        end
    end

    // Coefficient file, reset to the identity kernel; writable only while idle.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_r[i] <= (i == CENTRE) ? IDENT_COEF : {COEFW{1'b0}};
            end
        end else if (coef_we_s) begin
            coef_r[coef_idx] <= coef_data;
        end
    end

    conv_mac_lane #(.COEFW(COEFW), .SHIFT(SHIFT)) u_lane_r (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (accept_s),
        .acc_en  (acc_en_s),
        .norm_en (norm_en_s),
        .pix     (pix_s[R_LSB +: LANE_W]),
        .coef    (coef_sel_s),
        .result  (res_r_s)
    );

    conv_mac_lane #(.COEFW(COEFW), .SHIFT(SHIFT)) u_lane_g (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (accept_s),
        .acc_en  (acc_en_s),
        .norm_en (norm_en_s),
        .pix     (pix_s[G_LSB +: LANE_W]),
        .coef    (coef_sel_s),
        .result  (res_g_s)
    );

    conv_mac_lane #(.COEFW(COEFW), .SHIFT(SHIFT)) u_lane_b (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (accept_s),
        .acc_en  (acc_en_s),
        .norm_en (norm_en_s),
        .pix     (pix_s[B_LSB +: LANE_W]),
        .coef    (coef_sel_s),
        .result  (res_b_s)
    );

endmodule

// File: tb/tb_conv_alu.sv
// Self-checking bench for conv_alu: vector table plus hand sequences, scoreboard on wen_alu.
// Expected results for negative sums follow the CONV_ABS_EN setting of the build.
module tb_conv_alu;

    localparam int TAPS   = 25;
    localparam int DWIDTH = 12;
    localparam int AWIDTH = 19;
    localparam int WINW   = TAPS * DWIDTH;
    localparam int LAT    = 27;

`ifdef CONV_ABS_EN
    localparam logic [11:0] EXP_NEG3   = 12'h333;
    localparam logic [11:0] EXP_NEG2   = 12'h200;
    localparam logic [11:0] EXP_NEGMAX = 12'hFFF;
`else
    localparam logic [11:0] EXP_NEG3   = 12'h000;
    localparam logic [11:0] EXP_NEG2   = 12'h000;
    localparam logic [11:0] EXP_NEGMAX = 12'h000;
`endif

    logic              sys_clk = 1'b0;
    logic              rst = 1'b1;
    logic              win_valid = 1'b0;
    logic              win_ready;
    logic [WINW-1:0]   win_data = '0;
    logic [AWIDTH-1:0] win_addr = '0;
    logic              coef_wen = 1'b0;
    logic [4:0]        coef_idx = 5'd0;
    logic [7:0]        coef_data = 8'd0;
    logic [AWIDTH-1:0] waddr_alu;
    logic [DWIDTH-1:0] wdata_alu;
    logic              wen_alu;
    logic              busy;

    conv_alu dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_addr  (win_addr),
        .coef_wen  (coef_wen),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .waddr_alu (waddr_alu),
        .wdata_alu (wdata_alu),
        .wen_alu   (wen_alu),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
        int                due;
    } exp_t;

    typedef struct {
        bit          load;
        logic [7:0]  cc;
        logic [7:0]  co;
        logic [11:0] pc;
        logic [11:0] po;
        logic [18:0] addr;
        logic [11:0] exp_d;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[8];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_from = -1;
    int   busy_to = -1;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic [WINW-1:0] build_win(input logic [11:0] c, input logic [11:0] o);
        logic [WINW-1:0] w;
        w = '0;
        for (int t = 0; t < TAPS; t++) w[t*DWIDTH +: DWIDTH] = (t == 12) ? c : o;
        return w;
    endfunction

    // Monitor: busy window checks and scoreboard comparison on every write strobe.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!rst) begin
            if (cyc > busy_from && cyc <= busy_to) chk("ready_low_while_busy", {30'd0, win_ready, busy}, 32'd1);
            if (wen_alu) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_wen: got wen_alu=1 addr 0x%0h, expected no write (cycle %0d)", waddr_alu, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("wdata_alu", {20'd0, wdata_alu}, {20'd0, e.data});
                    chk("waddr_alu", {13'd0, waddr_alu}, {13'd0, e.addr});
                    chk("wen_latency_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic load_coefs(input logic [7:0] ctr, input logic [7:0] oth);
        for (int t = 0; t < TAPS; t++) begin
            tick();
            coef_wen  = 1'b1;
            coef_idx  = 5'(t);
            coef_data = (t == 12) ? ctr : oth;
        end
        tick();
        coef_wen = 1'b0;
    endtask

    task automatic wait_ready();
        int waited;
        waited = 0;
        while (!win_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!win_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got win_ready=0 after 100 cycles, expected 1");
        end
    endtask

    // Drives one window at the next ready negedge; returns one negedge after acceptance.
    task automatic send_window(input logic [WINW-1:0] w, input logic [AWIDTH-1:0] a,
                               input logic [DWIDTH-1:0] exp_d, input bit keep_valid, input bit push);
        exp_t e;
        tick();
        wait_ready();
        win_valid = 1'b1;
        win_data  = w;
        win_addr  = a;
        if (push) begin
            e.addr = a; e.data = exp_d; e.due = cyc + LAT;
            sb_q.push_back(e);
        end
        busy_from = cyc;
        busy_to   = cyc + LAT;
        tick();
        win_valid = keep_valid;
        win_data  = ~w;
        win_addr  = ~a;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < 200) begin
            tick();
            waited++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending writes, expected 0", sb_q.size());
            sb_q.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vt[0] = '{1'b0, 8'h00, 8'h00, 12'hA5C, 12'hFFF, 19'd1234,    12'hA5C};
        vt[1] = '{1'b1, 8'h01, 8'h01, 12'h111, 12'h111, 19'd1,       12'h111};
        vt[2] = '{1'b1, 8'h10, 8'h10, 12'hFFF, 12'hFFF, 19'h7FFFF,   12'hFFF};
        vt[3] = '{1'b1, 8'hF0, 8'h00, 12'h333, 12'hFFF, 19'd4660,    EXP_NEG3};
        vt[4] = '{1'b1, 8'h08, 8'h00, 12'h4F2, 12'hFFF, 19'd77,      12'h271};
        vt[5] = '{1'b1, 8'h20, 8'hFF, 12'h888, 12'h888, 19'h2AAAA,   12'h444};
        vt[6] = '{1'b1, 8'h00, 8'hFF, 12'h100, 12'h100, 19'h55555,   EXP_NEG2};
        vt[7] = '{1'b1, 8'h80, 8'h80, 12'hFFF, 12'hFFF, 19'd0,       EXP_NEGMAX};

        repeat (3) tick();
        chk("reset_win_ready", {31'd0, win_ready}, 32'd1);
        chk("reset_busy",      {31'd0, busy},      32'd0);
        chk("reset_wen",       {31'd0, wen_alu},   32'd0);
        chk("reset_waddr",     {13'd0, waddr_alu}, 32'd0);
        chk("reset_wdata",     {20'd0, wdata_alu}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vt[i].load) load_coefs(vt[i].cc, vt[i].co);
            send_window(build_win(vt[i].pc, vt[i].po), vt[i].addr, vt[i].exp_d, 1'b0, 1'b1);
            wait_drain();
        end

        // Coefficient write in the acceptance cycle takes effect for that window.
        load_coefs(8'h10, 8'h00);
        tick();
        wait_ready();
        coef_wen = 1'b1; coef_idx = 5'd12; coef_data = 8'h20;
        win_valid = 1'b1; win_data = build_win(12'h333, 12'hFFF); win_addr = 19'd555;
        e.addr = 19'd555; e.data = 12'h666; e.due = cyc + LAT;
        sb_q.push_back(e);
        busy_from = cyc; busy_to = cyc + LAT;
        tick();
        coef_wen = 1'b0; win_valid = 1'b0; win_data = '0;
        wait_drain();

        // Back-to-back windows with valid held; a coefficient write during ACC is dropped.
        load_coefs(8'h10, 8'h00);
        send_window(build_win(12'h5A3, 12'hFFF), 19'd100, 12'h5A3, 1'b1, 1'b1);
        coef_wen = 1'b1; coef_idx = 5'd12; coef_data = 8'h00;
        tick();
        coef_wen = 1'b0;
        send_window(build_win(12'h5A3, 12'hFFF), 19'd101, 12'h5A3, 1'b1, 1'b1);
        send_window(build_win(12'h5A3, 12'hFFF), 19'd102, 12'h5A3, 1'b0, 1'b1);
        wait_drain();

        // Reset at ACC cycle 10 aborts the window and restores the identity kernel.
        load_coefs(8'h20, 8'h00);
        send_window(build_win(12'h777, 12'h000), 19'd321, 12'h000, 1'b0, 1'b0);
        repeat (9) tick();
        busy_to = -1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_wen",       {31'd0, wen_alu},   32'd0);
        chk("abort_waddr",     {13'd0, waddr_alu}, 32'd0);
        chk("abort_wdata",     {20'd0, wdata_alu}, 32'd0);
        chk("abort_win_ready", {31'd0, win_ready}, 32'd1);
        win_valid = 1'b1; win_data = build_win(12'h9B4, 12'h123); win_addr = 19'd4321;
        e.addr = 19'd4321; e.data = 12'h9B4; e.due = cyc + LAT;
        sb_q.push_back(e);
        busy_from = cyc; busy_to = cyc + LAT;
        tick();
        win_valid = 1'b0; win_data = '0;
        wait_drain();

        repeat (40) tick();
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
